// File: rtl/atualizador_aster.sv
// Asteroid position updater: on each tick, sweeps memoria_aster entries, steps every asteroid
// one move along its direction with edge saturation, writes it back and flags ship collisions.
module atualizador_aster #(
  parameter int unsigned N_ASTER  = 16,
  parameter int unsigned PASSO    = 1,
  parameter logic [3:0]  CENTRO_X = 4'd7,
  parameter logic [3:0]  CENTRO_Y = 4'd7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic [9:0] mem_q,
  output logic [3:0] mem_addr,
  output logic       mem_we,
  output logic [9:0] mem_data,
  output logic       ocupado,
  output logic       pronto,
  output logic       colisao,
  output logic [3:0] colisao_idx,
  output logic [4:0] num_colisoes
);

  typedef enum logic [2:0] {
    StIdle,
    StCarrega,
    StLe,
    StEscreve,
    StFim
  } state_e;

  localparam logic [3:0] LastIdx = 4'(N_ASTER - 1);
  localparam logic [4:0] Passo5  = 5'(PASSO);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [9:0]  reg_aster_q, reg_aster_d;
  logic [4:0]  num_col_q, num_col_d;

  logic [3:0]  x_old, y_old, x_new, y_new;
  logic [1:0]  dir;
  logic        old_at_centre, new_at_centre, hit;
  logic [9:0]  word_new;

  // Step in 5 bits so the carry/borrow shows the edge was crossed, then clamp to the grid.
  function automatic logic [3:0] step_up(input logic [3:0] v);
    logic [4:0] sum;
    sum = {1'b0, v} + Passo5;
    return sum[4] ? 4'd15 : sum[3:0];
  endfunction

  function automatic logic [3:0] step_dn(input logic [3:0] v);
    logic [4:0] diff;
    diff = {1'b0, v} - Passo5;
    return diff[4] ? 4'd0 : diff[3:0];
  endfunction

  assign x_old = reg_aster_q[9:6];
  assign y_old = reg_aster_q[5:2];
  assign dir   = reg_aster_q[1:0];

  always_comb begin
    x_new         = x_old;
    y_new         = y_old;
    old_at_centre = (x_old == CENTRO_X) && (y_old == CENTRO_Y);
    if (!old_at_centre) begin
      unique case (dir)
        2'b00: x_new = step_up(x_old);
        2'b01: x_new = step_dn(x_old);
        2'b10: y_new = step_up(y_old);
        2'b11: y_new = step_dn(y_old);
        default: ;
      endcase
    end
    new_at_centre = (x_new == CENTRO_X) && (y_new == CENTRO_Y);
    hit           = !old_at_centre && new_at_centre;
    word_new      = {x_new, y_new, dir};
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    reg_aster_d = reg_aster_q;
    num_col_d   = num_col_q;
    mem_addr    = 4'd0;
    mem_we      = 1'b0;
    mem_data    = 10'd0;
    ocupado     = 1'b0;
    pronto      = 1'b0;
    colisao     = 1'b0;
    colisao_idx = 4'd0;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d   = StCarrega;
          idx_d     = 4'd0;
          num_col_d = 5'd0;
        end
      end
      StCarrega: begin
        ocupado  = 1'b1;
        mem_addr = idx_q;
        state_d  = StLe;
      end
      StLe: begin
        ocupado     = 1'b1;
        mem_addr    = idx_q;
        reg_aster_d = mem_q;
        state_d     = StEscreve;
      end
      StEscreve: begin
        ocupado  = 1'b1;
        mem_addr = idx_q;
        mem_we   = 1'b1;
        mem_data = word_new;
        if (hit) begin
          colisao     = 1'b1;
          colisao_idx = idx_q;
          num_col_d   = num_col_q + 5'd1;
        end
        if (idx_q < LastIdx) begin
          idx_d   = idx_q + 4'd1;
          state_d = StCarrega;
        end else begin
          state_d = StFim;
        end
      end
      StFim: begin
        pronto  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      idx_q       <= 4'd0;
      reg_aster_q <= 10'd0;
      num_col_q   <= 5'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      reg_aster_q <= reg_aster_d;
      num_col_q   <= num_col_d;
    end
  end

  assign num_colisoes = num_col_q;

endmodule

// File: tb/tb_atualizador_aster.sv
// Directed bench for atualizador_aster: four parameterisations, each with its own
// synchronous-read memory model, checked against hand-computed words and cycle counts.
module tb_atualizador_aster;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       tick         [4];
  logic [9:0] mem_q        [4];
  logic [3:0] mem_addr     [4];
  logic       mem_we       [4];
  logic [9:0] mem_data     [4];
  logic       ocupado      [4];
  logic       pronto       [4];
  logic       colisao      [4];
  logic [3:0] colisao_idx  [4];
  logic [4:0] num_colisoes [4];

  logic [9:0] mem     [4][16];
  logic [9:0] pre_img [16];
  logic       pre_we;
  int         pre_g;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  // Instance 0: defaults; 1: PASSO=3; 2: PASSO=2; 3: N_ASTER=1.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    atualizador_aster #(
      .N_ASTER ((g == 3) ? 1 : 16),
      .PASSO   ((g == 1) ? 3 : ((g == 2) ? 2 : 1)),
      .CENTRO_X(4'd7),
      .CENTRO_Y(4'd7)
    ) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tick        (tick[g]),
      .mem_q       (mem_q[g]),
      .mem_addr    (mem_addr[g]),
      .mem_we      (mem_we[g]),
      .mem_data    (mem_data[g]),
      .ocupado     (ocupado[g]),
      .pronto      (pronto[g]),
      .colisao     (colisao[g]),
      .colisao_idx (colisao_idx[g]),
      .num_colisoes(num_colisoes[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (mem_we[g]) mem[g][mem_addr[g]] <= mem_data[g];
      mem_q[g] <= mem[g][mem_addr[g]];
    end
    if (pre_we) begin
      for (int i = 0; i < 16; i++) mem[pre_g][i] <= pre_img[i];
    end
  end

  // Idle-zero rules on write data / collision index, and ocupado never overlapping pronto.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (!mem_we[g] && mem_data[g] != 10'd0) viol++;
      if (!colisao[g] && colisao_idx[g] != 4'd0) viol++;
      if (ocupado[g] && pronto[g]) viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] w(input int x, input int y, input int d);
    return {4'(x), 4'(y), 2'(d)};
  endfunction

  task automatic fill_default();
    for (int i = 0; i < 16; i++) pre_img[i] = w(0, 0, 1);
  endtask

  task automatic load(input int g);
    pre_g  = g;
    pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Pulses tick for one cycle and follows the sweep until pronto (bounded); returns at the
  // negedge where pronto is high. cnt counts cycles after the tick cycle.
  task automatic run_sweep(input int g, output int lat, output int ncol, output int cidx,
                           output int ccyc, output int addr1);
    int cnt;
    lat   = -1;
    ncol  = 0;
    cidx  = -1;
    ccyc  = -1;
    addr1 = -1;
    tick[g] = 1'b1;
    @(negedge clk);
    tick[g] = 1'b0;
    cnt = 1;
    addr1 = int'(mem_addr[g]);
    while (cnt <= 60) begin
      if (colisao[g]) begin
        ncol++;
        cidx = int'(colisao_idx[g]);
        ccyc = cnt;
      end
      if (pronto[g]) begin
        lat = cnt;
        break;
      end
      @(negedge clk);
      cnt++;
    end
  endtask

  int lat, ncol, cidx, ccyc, addr1, np, p1, p2;

  initial begin
    reset_n = 1'b0;
    pre_we  = 1'b0;
    pre_g   = 0;
    for (int g = 0; g < 4; g++) tick[g] = 1'b0;
    fill_default();
    #1;
    check("rst_outputs", {ocupado[0], pronto[0], mem_we[0], mem_addr[0], num_colisoes[0]}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("post_rst_we", mem_we[0], 0);

    // Basic sweep from a known image.
    fill_default();
    pre_img[0] = w(7, 14, 3);
    pre_img[3] = w(0, 7, 0);
    pre_img[9] = w(7, 7, 2);
    load(0);
    run_sweep(0, lat, ncol, cidx, ccyc, addr1);
    check("t2_latency", lat, 49);
    check("t2_ncol", ncol, 0);
    check("t2_num_col", num_colisoes[0], 0);
    check("t2_ocupado_fim", ocupado[0], 0);
    @(negedge clk);
    check("t2_pronto_pulse", pronto[0], 0);
    check("t2_idx0", mem[0][0], w(7, 13, 3));
    check("t2_idx3", mem[0][3], w(1, 7, 0));
    check("t2_idx9", mem[0][9], w(7, 7, 2));
    check("t2_idx5", mem[0][5], w(0, 0, 1));

    // Reset asserted in LE of idx 5.
    load(0);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    for (int c = 1; c < 17; c++) @(negedge clk);
    check("t1_le5_addr", mem_addr[0], 5);
    check("t1_le5_busy", ocupado[0], 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t1_rst_outs", {ocupado[0], mem_we[0], pronto[0], colisao[0], mem_addr[0],
                          mem_data[0], num_colisoes[0]}, 0);
    check("t1_idx4_done", mem[0][4], w(0, 0, 1));
    check("t1_idx0_done", mem[0][0], w(7, 13, 3));
    reset_n = 1'b1;
    @(negedge clk);
    check("t1_we_after_rst", mem_we[0], 0);
    run_sweep(0, lat, ncol, cidx, ccyc, addr1);
    check("t1_restart_addr", addr1, 0);
    check("t1_latency", lat, 49);
    check("t1_idx0_twice", mem[0][0], w(7, 12, 3));
    check("t1_idx3_twice", mem[0][3], w(2, 7, 0));

    // Single collision at idx 2.
    fill_default();
    pre_img[2] = w(6, 7, 0);
    load(0);
    run_sweep(0, lat, ncol, cidx, ccyc, addr1);
    check("t3_ncol", ncol, 1);
    check("t3_cidx", cidx, 2);
    check("t3_ccyc", ccyc, 9);
    check("t3_num_col", num_colisoes[0], 1);
    check("t3_idx2", mem[0][2], w(7, 7, 0));

    // Saturation with PASSO=3, plus a collision reached by a 3-cell step.
    fill_default();
    pre_img[0] = w(14, 7, 0);
    pre_img[1] = w(7, 1, 3);
    pre_img[2] = w(1, 7, 1);
    pre_img[3] = w(4, 7, 0);
    load(1);
    run_sweep(1, lat, ncol, cidx, ccyc, addr1);
    check("t4_latency", lat, 49);
    check("t4_sat_x_hi", mem[1][0], w(15, 7, 0));
    check("t4_sat_y_lo", mem[1][1], w(7, 0, 3));
    check("t4_sat_x_lo", mem[1][2], w(0, 7, 1));
    check("t4_hit_idx3", mem[1][3], w(7, 7, 0));
    check("t4_cidx", cidx, 3);
    check("t4_num_col", num_colisoes[1], 1);

    // Overshoot with PASSO=2; entry already on the centre stays put.
    fill_default();
    pre_img[0] = w(6, 7, 0);
    pre_img[1] = w(7, 7, 1);
    load(2);
    run_sweep(2, lat, ncol, cidx, ccyc, addr1);
    check("t5_overshoot", mem[2][0], w(8, 7, 0));
    check("t5_centre_kept", mem[2][1], w(7, 7, 1));
    check("t5_ncol", ncol, 0);
    check("t5_num_col", num_colisoes[2], 0);

    // N_ASTER=1 with tick held high: one sweep per IDLE visit.
    fill_default();
    pre_img[0] = w(0, 7, 0);
    load(3);
    np = 0;
    p1 = -1;
    p2 = -1;
    tick[3] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (c == 9) tick[3] = 1'b0;
      if (pronto[3]) begin
        np++;
        if (p1 < 0) p1 = c;
        else p2 = c;
      end
    end
    check("t6_num_pronto", np, 2);
    check("t6_first_pronto", p1, 4);
    check("t6_second_pronto", p2, 9);
    check("t6_idx0", mem[3][0], w(2, 7, 0));

    check("monitor_rules", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
